// File: rtl/dtw_pkg.sv
`default_nettype none
// ============================================================================
//  Package     : dtw_pkg
//  Description : Shared constants and the controller state encoding for the
//                dtw_sequencer codebase slice.
//  Revision    : 1.0 - initial release
// ============================================================================
package dtw_pkg;

    localparam int FRAMES    = 50;               // frames per utterance
    localparam int FEATS     = 12;               // feature bytes per frame
    localparam int SCORE_W   = 26;               // engine score width
    localparam int UTT_BYTES = FRAMES * FEATS;   // bytes per utterance
    localparam int ADDR_W    = 10;               // frame buffer address width

    typedef enum logic [2:0] {
        IDLE      = 3'd0,
        CAPTURE   = 3'd1,
        LAUNCH    = 3'd2,
        STREAM    = 3'd3,
        WAIT_DONE = 3'd4,
        COMPARE   = 3'd5,
        REPORT    = 3'd6
    } state_t;

endpackage : dtw_pkg
`default_nettype wire

// File: rtl/dtw_frame_buffer.sv
`default_nettype none
// ============================================================================
//  Module      : dtw_frame_buffer
//  Description : UTT_BYTES x 8 single-port RAM holding one captured utterance.
//                Synchronous read; the read register only updates when re is
//                high, so the last byte read stays on rdata between reads.
//  Ports       : clock   - system clock
//                reset_n - asynchronous active-low reset (read register only)
//                we      - write enable
//                re      - read enable
//                addr    - shared read/write address
//                wdata   - write byte
//                rdata   - registered read byte
//  Revision    : 1.0 - initial release
// ============================================================================
module dtw_frame_buffer
    import dtw_pkg::*;
(
    input  logic              clock,
    input  logic              reset_n,
    input  logic              we,
    input  logic              re,
    input  logic [ADDR_W-1:0] addr,
    input  logic [7:0]        wdata,
    output logic [7:0]        rdata
);

    logic [7:0] r_mem [UTT_BYTES];
    logic [7:0] r_rdata;

    // Array itself carries no reset so it maps onto block RAM.
    always_ff @(posedge clock) begin
        if (we) begin
            r_mem[addr] <= wdata;
        end
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            r_rdata <= 8'd0;
        end else if (re) begin
            r_rdata <= r_mem[addr];
        end
    end

    assign rdata = r_rdata;

endmodule : dtw_frame_buffer
`default_nettype wire

// File: rtl/dtw_sequencer.sv
`default_nettype none
// ============================================================================
//  Module      : dtw_sequencer
//  Description : Command-driven controller for a bank of SLOTS dtw_score
//                engines. TRAIN captures an utterance and streams it to one
//                engine with train_enable set; RECOGNIZE streams it to every
//                trained engine, then scans the scores for the lowest one.
//  Ports       : clock/reset_n          - clock, async active-low reset
//                cmd_valid/cmd_ready    - command handshake (ready in IDLE)
//                cmd_train/cmd_slot     - TRAIN(1)/RECOGNIZE(0), TRAIN slot
//                threshold              - match acceptance limit
//                feat_valid/ready/data  - utterance byte input (CAPTURE only)
//                dtw_start/train/data   - engine start, train enable, byte
//                dtw_done/dtw_score     - engine done levels and scores
//                result_*               - recognition result and strobe
//                trained                - slots holding a template
//                busy/error             - not idle / bad slot or timeout
//  Revision    : 1.0 - initial release
// ============================================================================
module dtw_sequencer
    import dtw_pkg::*;
#(
    parameter int SLOTS   = 4,
    parameter int SLOT_W  = 2,
    parameter int TIMEOUT = 2048
) (
    input  logic                     clock,
    input  logic                     reset_n,
    input  logic                     cmd_valid,
    output logic                     cmd_ready,
    input  logic                     cmd_train,
    input  logic [SLOT_W-1:0]        cmd_slot,
    input  logic [SCORE_W-1:0]       threshold,
    input  logic                     feat_valid,
    output logic                     feat_ready,
    input  logic [7:0]               feat_data,
    output logic [SLOTS-1:0]         dtw_start,
    output logic [SLOTS-1:0]         dtw_train,
    output logic [7:0]               dtw_data,
    input  logic [SLOTS-1:0]         dtw_done,
    input  logic [SLOTS*SCORE_W-1:0] dtw_score,
    output logic                     result_valid,
    output logic [SLOT_W-1:0]        result_slot,
    output logic [SCORE_W-1:0]       result_score,
    output logic                     result_match,
    output logic [SLOTS-1:0]         trained,
    output logic                     busy,
    output logic                     error
);

    localparam int TMR_W = $clog2(TIMEOUT) + 1;
    localparam int SUB_W = $clog2(FEATS + 1);
    localparam int FRM_W = $clog2(FRAMES);

    state_t               r_state;
    state_t               w_next;

    logic                 r_cmd_train;
    logic [SLOT_W-1:0]    r_cmd_slot;
    logic [SLOTS-1:0]     r_target;
    logic [SLOTS-1:0]     r_trained;
    logic [ADDR_W-1:0]    r_wr_addr;
    logic [ADDR_W-1:0]    r_rd_addr;
    logic                 r_lead;
    logic [SUB_W-1:0]     r_sub;
    logic [FRM_W-1:0]     r_frame;
    logic [TMR_W-1:0]     r_wait_cnt;
    logic [SLOT_W-1:0]    r_scan;
    logic [SLOT_W-1:0]    r_best_slot;
    logic [SCORE_W-1:0]   r_best_score;
    logic                 r_best_found;
    logic [SLOT_W-1:0]    r_res_slot;
    logic [SCORE_W-1:0]   r_res_score;
    logic                 r_res_match;
    logic                 r_error;

    logic                 w_cmd_fire;
    logic                 w_bad_slot;
    logic [SLOTS-1:0]     w_cmd_onehot;
    logic [SLOTS-1:0]     w_launch_set;
    logic                 w_feat_fire;
    logic                 w_capture_last;
    logic                 w_stream_last;
    logic                 w_rd_en;
    logic                 w_all_done;
    logic                 w_timeout;
    logic [SCORE_W-1:0]   w_cur_score;
    logic                 w_take;
    logic                 w_scan_last;
    logic [SLOT_W-1:0]    w_fin_slot;
    logic [SCORE_W-1:0]   w_fin_score;
    logic                 w_fin_found;
    logic [ADDR_W-1:0]    w_ram_addr;

    // ------------------------------------------------------------------
    // Combinational datapath helpers
    // ------------------------------------------------------------------
    assign w_cmd_fire     = cmd_valid & cmd_ready;
    assign w_bad_slot     = cmd_train && (int'(cmd_slot) >= SLOTS);
    assign w_cmd_onehot   = SLOTS'(1) << r_cmd_slot;
    assign w_launch_set   = r_cmd_train ? w_cmd_onehot : r_trained;
    assign w_feat_fire    = feat_valid & feat_ready;
    assign w_capture_last = w_feat_fire && (r_wr_addr == ADDR_W'(UTT_BYTES - 1));

    // Pacer: one lead-in cycle, then FEATS data cycles and one gap per frame.
    assign w_stream_last  = !r_lead && (r_sub == SUB_W'(FEATS))
                            && (r_frame == FRM_W'(FRAMES - 1));

    // Read one cycle ahead of each data cycle. No read is issued ahead of a
    // gap, so the RAM register keeps the frame's last byte on dtw_data.
    assign w_rd_en = (r_state == STREAM) &&
                     (r_lead ||
                      (r_sub < SUB_W'(FEATS - 1)) ||
                      ((r_sub == SUB_W'(FEATS)) && (r_frame != FRM_W'(FRAMES - 1))));

    // Done levels from the previous operation may still be high for a couple
    // of cycles after start, so the first two WAIT_DONE cycles are ignored.
    assign w_all_done = ((dtw_done & r_target) == r_target) && (r_wait_cnt >= TMR_W'(2));
    assign w_timeout  = !w_all_done && (r_wait_cnt == TMR_W'(TIMEOUT - 1));

    // Strict less-than keeps the lowest slot index on equal scores.
    assign w_cur_score = dtw_score[r_scan*SCORE_W +: SCORE_W];
    assign w_take      = r_target[r_scan] && (!r_best_found || (w_cur_score < r_best_score));
    assign w_scan_last = (r_scan == SLOT_W'(SLOTS - 1));
    assign w_fin_slot  = w_take ? r_scan      : r_best_slot;
    assign w_fin_score = w_take ? w_cur_score : r_best_score;
    assign w_fin_found = r_best_found | w_take;

    assign w_ram_addr  = (r_state == CAPTURE) ? r_wr_addr : r_rd_addr;

    dtw_frame_buffer u_frame_buffer (
        .clock   (clock),
        .reset_n (reset_n),
        .we      (w_feat_fire),
        .re      (w_rd_en),
        .addr    (w_ram_addr),
        .wdata   (feat_data),
        .rdata   (dtw_data)
    );

    // ------------------------------------------------------------------
    // State register
    // ------------------------------------------------------------------
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    // ------------------------------------------------------------------
    // Next state and state-decoded outputs
    // ------------------------------------------------------------------
    always_comb begin
        w_next       = r_state;
        cmd_ready    = 1'b0;
        feat_ready   = 1'b0;
        busy         = 1'b1;
        dtw_start    = '0;
        dtw_train    = '0;
        result_valid = 1'b0;

        case (r_state)
            IDLE: begin
                busy = 1'b0;
                // Gated with reset_n so every output reads 0 while in reset.
                cmd_ready = reset_n;
                if (w_cmd_fire && !w_bad_slot) begin
                    w_next = CAPTURE;
                end
            end
            CAPTURE: begin
                feat_ready = 1'b1;
                if (w_capture_last) begin
                    w_next = LAUNCH;
                end
            end
            LAUNCH: begin
                dtw_start = w_launch_set;
                if (r_cmd_train) begin
                    dtw_train = w_cmd_onehot;
                end
                w_next = (w_launch_set == '0) ? REPORT : STREAM;
            end
            STREAM: begin
                if (r_cmd_train) begin
                    dtw_train = w_cmd_onehot;
                end
                if (w_stream_last) begin
                    w_next = WAIT_DONE;
                end
            end
            WAIT_DONE: begin
                if (r_cmd_train) begin
                    dtw_train = w_cmd_onehot;
                end
                if (w_all_done) begin
                    w_next = r_cmd_train ? IDLE : COMPARE;
                end else if (w_timeout) begin
                    w_next = IDLE;
                end
            end
            COMPARE: begin
                if (w_scan_last) begin
                    w_next = REPORT;
                end
            end
            REPORT: begin
                result_valid = 1'b1;
                w_next       = IDLE;
            end
            default: begin
                w_next = IDLE;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // Datapath registers: command latch, counters, scan, results
    // ------------------------------------------------------------------
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            r_cmd_train  <= 1'b0;
            r_cmd_slot   <= '0;
            r_target     <= '0;
            r_trained    <= '0;
            r_wr_addr    <= '0;
            r_rd_addr    <= '0;
            r_lead       <= 1'b0;
            r_sub        <= '0;
            r_frame      <= '0;
            r_wait_cnt   <= '0;
            r_scan       <= '0;
            r_best_slot  <= '0;
            r_best_score <= '1;
            r_best_found <= 1'b0;
            r_res_slot   <= '0;
            r_res_score  <= '0;
            r_res_match  <= 1'b0;
            r_error      <= 1'b0;
        end else begin
            r_error <= 1'b0;
            case (r_state)
                IDLE: begin
                    if (w_cmd_fire) begin
                        r_cmd_train <= cmd_train;
                        r_cmd_slot  <= cmd_slot;
                        r_wr_addr   <= '0;
                        if (w_bad_slot) begin
                            r_error <= 1'b1;
                        end
                    end
                end
                CAPTURE: begin
                    if (w_feat_fire) begin
                        r_wr_addr <= r_wr_addr + ADDR_W'(1);
                    end
                end
                LAUNCH: begin
                    r_target     <= w_launch_set;
                    r_rd_addr    <= '0;
                    r_lead       <= 1'b1;
                    r_sub        <= '0;
                    r_frame      <= '0;
                    r_scan       <= '0;
                    r_best_slot  <= '0;
                    r_best_score <= '1;
                    r_best_found <= 1'b0;
                    if (w_launch_set == '0) begin
                        r_res_slot  <= '0;
                        r_res_score <= '1;
                        r_res_match <= 1'b0;
                    end
                end
                STREAM: begin
                    r_wait_cnt <= '0;
                    if (w_rd_en) begin
                        r_rd_addr <= r_rd_addr + ADDR_W'(1);
                    end
                    if (r_lead) begin
                        r_lead <= 1'b0;
                    end else if (r_sub == SUB_W'(FEATS)) begin
                        r_sub   <= '0;
                        r_frame <= r_frame + FRM_W'(1);
                    end else begin
                        r_sub <= r_sub + SUB_W'(1);
                    end
                end
                WAIT_DONE: begin
                    r_wait_cnt <= r_wait_cnt + TMR_W'(1);
                    if (w_all_done) begin
                        if (r_cmd_train) begin
                            r_trained <= r_trained | r_target;
                        end
                    end else if (w_timeout) begin
                        // A template that never finished is not trusted.
                        r_error   <= 1'b1;
                        r_trained <= r_trained & ~r_target;
                    end
                end
                COMPARE: begin
                    r_scan       <= r_scan + SLOT_W'(1);
                    r_best_slot  <= w_fin_slot;
                    r_best_score <= w_fin_score;
                    r_best_found <= w_fin_found;
                    if (w_scan_last) begin
                        r_res_slot  <= w_fin_found ? w_fin_slot  : '0;
                        r_res_score <= w_fin_found ? w_fin_score : '1;
                        r_res_match <= w_fin_found && (w_fin_score < threshold);
                    end
                end
                default: begin
                end
            endcase
        end
    end

    assign result_slot  = r_res_slot;
    assign result_score = r_res_score;
    assign result_match = r_res_match;
    assign trained      = r_trained;
    assign error        = r_error;

endmodule : dtw_sequencer
`default_nettype wire
